// File: rtl/modbus_func_engine.sv
// Modbus RTU slave function engine: validates FC03/04/06 requests, serves register
// reads into the response DPRAM, issues single-register writes and signals completion.
module modbus_func_engine #(
  parameter int N_HOLD     = 4,
  parameter int N_INPUT    = 8,
  parameter int BASE_HOLD  = 1,
  parameter int BASE_INPUT = 1,
  parameter int MAX_QTY    = 125,
  parameter int WR_TIMEOUT = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rx_message_done,
  input  logic [7:0]             func_code,
  input  logic [15:0]            addr,
  input  logic [15:0]            data,
  input  logic                   exception_done,
  input  logic [7:0]             exception_in,
  input  logic [N_HOLD*16-1:0]   hold_regs,
  input  logic [N_INPUT*16-1:0]  input_regs,
  output logic                   reg_wen,
  output logic [15:0]            reg_waddr,
  output logic [15:0]            reg_wdat,
  input  logic                   reg_w_done,
  input  logic                   reg_w_status,
  output logic                   dpram_wen,
  output logic [7:0]             dpram_addr,
  output logic [15:0]            dpram_wdata,
  output logic [7:0]             func_code_r,
  output logic [7:0]             tx_quantity,
  output logic [7:0]             exception_out,
  output logic                   busy,
  output logic                   handler_done
);

  localparam int HW = (N_HOLD > 1) ? $clog2(N_HOLD) : 1;
  localparam int IW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int XW = (HW > IW) ? HW : IW;
  localparam int TW = $clog2(WR_TIMEOUT + 1);
  localparam logic [16:0] HOLD_LO  = 17'(BASE_HOLD);
  localparam logic [16:0] HOLD_END = 17'(BASE_HOLD + N_HOLD);
  localparam logic [16:0] IN_LO    = 17'(BASE_INPUT);
  localparam logic [16:0] IN_END   = 17'(BASE_INPUT + N_INPUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_fc;
  logic [15:0]   r_addr;
  logic [15:0]   r_data;
  logic [XW-1:0] r_idx;
  logic [7:0]    r_k;
  logic [TW-1:0] r_tcnt;
  logic          r_reg_wen;
  logic [15:0]   r_reg_waddr;
  logic [15:0]   r_reg_wdat;
  logic          r_dpram_wen;
  logic [7:0]    r_dpram_addr;
  logic [15:0]   r_dpram_wdata;
  logic [7:0]    r_tx_quantity;
  logic [7:0]    r_exception_out;
  logic          r_handler_done;

  logic [15:0] w_hold [N_HOLD];
  logic [15:0] w_in   [N_INPUT];

  genvar gi;
  generate
    for (gi = 0; gi < N_HOLD; gi++) begin : g_hold
      assign w_hold[gi] = hold_regs[16*gi +: 16];
    end
    for (gi = 0; gi < N_INPUT; gi++) begin : g_in
      assign w_in[gi] = input_regs[16*gi +: 16];
    end
  endgenerate

  logic        w_is_rd;
  logic        w_fc_ok;
  logic [16:0] w_lo;
  logic [16:0] w_end;
  logic [16:0] w_last;
  logic        w_qty_ok;
  logic        w_range_ok;
  logic        w_wr_ok;
  logic [15:0] w_rd_word;

  // Range checks use 17-bit arithmetic so addr+qty cannot wrap into the table.
  assign w_is_rd    = (r_fc == 8'h03) || (r_fc == 8'h04);
  assign w_fc_ok    = w_is_rd || (r_fc == 8'h06);
  assign w_lo       = (r_fc == 8'h03) ? HOLD_LO : IN_LO;
  assign w_end      = (r_fc == 8'h03) ? HOLD_END : IN_END;
  assign w_last     = {1'b0, r_addr} + {1'b0, r_data};
  assign w_qty_ok   = (r_data != 16'd0) && (r_data <= 16'(MAX_QTY));
  assign w_range_ok = ({1'b0, r_addr} >= w_lo) && (w_last <= w_end);
  assign w_wr_ok    = ({1'b0, r_addr} >= HOLD_LO) && ({1'b0, r_addr} < HOLD_END);
  assign w_rd_word  = (r_fc == 8'h03) ? w_hold[r_idx[HW-1:0]] : w_in[r_idx[IW-1:0]];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= S_IDLE;
      r_fc            <= 8'd0;
      r_addr          <= 16'd0;
      r_data          <= 16'd0;
      r_idx           <= '0;
      r_k             <= 8'd0;
      r_tcnt          <= '0;
      r_reg_wen       <= 1'b0;
      r_reg_waddr     <= 16'd0;
      r_reg_wdat      <= 16'd0;
      r_dpram_wen     <= 1'b0;
      r_dpram_addr    <= 8'd0;
      r_dpram_wdata   <= 16'd0;
      r_tx_quantity   <= 8'd0;
      r_exception_out <= 8'd0;
      r_handler_done  <= 1'b0;
    end else begin
      r_handler_done <= 1'b0;
      r_reg_wen      <= 1'b0;
      r_dpram_wen    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_message_done) begin
            r_fc   <= func_code;
            r_addr <= addr;
            r_data <= data;
          end
          if (exception_done) begin
            if (exception_in != 8'd0) begin
              r_exception_out <= exception_in;
              r_tx_quantity   <= 8'd0;
              r_state         <= S_DONE;
            end else begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          r_k    <= 8'd0;
          r_tcnt <= '0;
          r_idx  <= XW'(r_addr - w_lo[15:0]);
          if (!w_fc_ok) begin
            r_exception_out <= 8'h01;
            r_tx_quantity   <= 8'd0;
            r_state         <= S_DONE;
          end else if (w_is_rd && !w_qty_ok) begin
            r_exception_out <= 8'h03;
            r_tx_quantity   <= 8'd0;
            r_state         <= S_DONE;
          end else if ((w_is_rd && !w_range_ok) || (!w_is_rd && !w_wr_ok)) begin
            r_exception_out <= 8'h02;
            r_tx_quantity   <= 8'd0;
            r_state         <= S_DONE;
          end else begin
            r_state <= w_is_rd ? S_READ : S_WR_REQ;
          end
        end
        S_READ: begin
          if (r_k < r_data[7:0]) begin
            r_dpram_wen   <= 1'b1;
            r_dpram_addr  <= r_k;
            r_dpram_wdata <= w_rd_word;
            r_k           <= r_k + 8'd1;
            r_idx         <= r_idx + XW'(1);
          end else begin
            r_tx_quantity   <= r_data[7:0];
            r_exception_out <= 8'd0;
            r_state         <= S_DONE;
          end
        end
        S_WR_REQ: begin
          r_reg_wen   <= 1'b1;
          r_reg_waddr <= r_addr - 16'(BASE_HOLD);
          r_reg_wdat  <= r_data;
          r_state     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (reg_w_done) begin
            r_exception_out <= reg_w_status ? 8'h04 : 8'h00;
            r_tx_quantity   <= reg_w_status ? 8'd0 : 8'd1;
            r_state         <= S_DONE;
          end else if (r_tcnt == TW'(WR_TIMEOUT - 1)) begin
            r_exception_out <= 8'h04;
            r_tx_quantity   <= 8'd0;
            r_state         <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_DONE: begin
          r_handler_done <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reg_wen       = r_reg_wen;
  assign reg_waddr     = r_reg_waddr;
  assign reg_wdat      = r_reg_wdat;
  assign dpram_wen     = r_dpram_wen;
  assign dpram_addr    = r_dpram_addr;
  assign dpram_wdata   = r_dpram_wdata;
  assign func_code_r   = r_fc;
  assign tx_quantity   = r_tx_quantity;
  assign exception_out = r_exception_out;
  assign busy          = (r_state != S_IDLE);
  assign handler_done  = r_handler_done;

endmodule

// File: tb/tb_modbus_func_engine.sv
// Scoreboard bench for modbus_func_engine: expected DPRAM writes, register writes and
// responses are queued as requests are issued and compared as the engine produces them.
module tb_modbus_func_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_message_done;
  logic [7:0]   func_code;
  logic [15:0]  addr;
  logic [15:0]  data;
  logic         exception_done;
  logic [7:0]   exception_in;
  logic [63:0]  hold_regs;
  logic [127:0] input_regs;
  logic         reg_wen;
  logic [15:0]  reg_waddr;
  logic [15:0]  reg_wdat;
  logic         reg_w_done;
  logic         reg_w_status;
  logic         dpram_wen;
  logic [7:0]   dpram_addr;
  logic [15:0]  dpram_wdata;
  logic [7:0]   func_code_r;
  logic [7:0]   tx_quantity;
  logic [7:0]   exception_out;
  logic         busy;
  logic         handler_done;

  modbus_func_engine dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .rx_message_done (rx_message_done),
    .func_code       (func_code),
    .addr            (addr),
    .data            (data),
    .exception_done  (exception_done),
    .exception_in    (exception_in),
    .hold_regs       (hold_regs),
    .input_regs      (input_regs),
    .reg_wen         (reg_wen),
    .reg_waddr       (reg_waddr),
    .reg_wdat        (reg_wdat),
    .reg_w_done      (reg_w_done),
    .reg_w_status    (reg_w_status),
    .dpram_wen       (dpram_wen),
    .dpram_addr      (dpram_addr),
    .dpram_wdata     (dpram_wdata),
    .func_code_r     (func_code_r),
    .tx_quantity     (tx_quantity),
    .exception_out   (exception_out),
    .busy            (busy),
    .handler_done    (handler_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int wr_mode = 0;

  logic [15:0] hold_m [4];
  logic [15:0] inp_m  [8];
  logic [23:0] dp_q [$];
  logic [31:0] wr_q [$];
  logic [23:0] resp_q [$];
  logic [23:0] dp_e;
  logic [31:0] wr_e;
  logic [23:0] resp_e;

  logic [83:0] all_out;
  assign all_out = {reg_wen, reg_waddr, reg_wdat, dpram_wen, dpram_addr, dpram_wdata,
                    func_code_r, tx_quantity, exception_out, busy, handler_done};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dpram_wen) begin
      if (dp_q.size() == 0) chk("dp_unexpected", 1, 0);
      else begin
        dp_e = dp_q.pop_front();
        chk("dp_addr", dpram_addr, dp_e[23:16]);
        chk("dp_data", dpram_wdata, dp_e[15:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && handler_done) begin
      if (resp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        resp_e = resp_q.pop_front();
        chk("resp_fc", func_code_r, resp_e[23:16]);
        chk("resp_exc", exception_out, resp_e[15:8]);
        chk("resp_txq", tx_quantity, resp_e[7:0]);
        $display("txn fc=%02h exc=%02h txq=%0d", func_code_r, exception_out, tx_quantity);
      end
    end
  end

  // Register-file stand-in: answers each write request according to wr_mode
  // (0 = success, 1 = failure status, 2 = never answers).
  initial begin
    reg_w_done   = 1'b0;
    reg_w_status = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && reg_wen) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", reg_waddr, wr_e[31:16]);
          chk("wr_data", reg_wdat, wr_e[15:0]);
        end
        if (wr_mode != 2) begin
          repeat (5) @(negedge clk);
          reg_w_done   = 1'b1;
          reg_w_status = (wr_mode == 1);
          @(negedge clk);
          reg_w_done   = 1'b0;
          reg_w_status = 1'b0;
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] exin);
    @(negedge clk);
    rx_message_done = 1'b1;
    func_code = fc;
    addr = a;
    data = d;
    @(negedge clk);
    rx_message_done = 1'b0;
    exception_done = 1'b1;
    exception_in = exin;
    @(posedge clk);
    @(negedge clk);
    exception_done = 1'b0;
    exception_in = 8'h00;
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (lat < 3000 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (handler_done) got = 1;
    end
    if (!got) chk({tag, "_no_done"}, 0, 1);
  endtask

  task automatic run_req(input string tag, input logic [7:0] fc, input logic [15:0] a,
                         input logic [15:0] d, input logic [7:0] exin, input logic [7:0] exp_exc,
                         input logic [7:0] exp_tx, input int exp_lat);
    int lat;
    resp_q.push_back({fc, exp_exc, exp_tx});
    if (exp_exc == 8'h00 && exin == 8'h00 && (fc == 8'h03 || fc == 8'h04)) begin
      for (int k = 0; k < int'(exp_tx); k++) begin
        if (fc == 8'h03) dp_q.push_back({8'(k), hold_m[int'(a) - 1 + k]});
        else             dp_q.push_back({8'(k), inp_m[int'(a) - 1 + k]});
      end
    end
    if (fc == 8'h06 && exin == 8'h00 && a >= 16'd1 && a <= 16'd4)
      wr_q.push_back({a - 16'd1, d});
    send_req(fc, a, d, exin);
    wait_done(tag, lat);
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    if (exp_lat == -2) chk({tag, "_timeout_window"}, (lat >= 1024 && lat <= 1032), 1);
    @(negedge clk);
    chk({tag, "_one_pulse"}, handler_done, 0);
    chk({tag, "_dp_left"}, dp_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int extra;
    for (int i = 0; i < 4; i++) begin
      hold_m[i] = 16'hAAAA + 16'(i) * 16'h1111;
      hold_regs[16*i +: 16] = hold_m[i];
    end
    for (int i = 0; i < 8; i++) begin
      inp_m[i] = 16'h1000 + 16'(i) * 16'h0111;
      input_regs[16*i +: 16] = inp_m[i];
    end
    rst_n = 1'b0;
    rx_message_done = 1'b0;
    func_code = 8'h00;
    addr = 16'h0000;
    data = 16'h0000;
    exception_done = 1'b0;
    exception_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_req("fc03_a1_q4",   8'h03, 16'd1,      16'd4,   8'h00, 8'h00, 8'd4, 7);
    run_req("fc04_a8_q1",   8'h04, 16'd8,      16'd1,   8'h00, 8'h00, 8'd1, 4);
    run_req("fc04_a8_q2",   8'h04, 16'd8,      16'd2,   8'h00, 8'h02, 8'd0, 2);
    run_req("fc04_q0",      8'h04, 16'd1,      16'd0,   8'h00, 8'h03, 8'd0, 2);
    run_req("fc04_q126",    8'h04, 16'd1,      16'd126, 8'h00, 8'h03, 8'd0, 2);
    run_req("fc10",         8'h10, 16'd1,      16'd1,   8'h00, 8'h01, 8'd0, 2);
    run_req("fc04_wrap",    8'h04, 16'hFFFF,   16'd2,   8'h00, 8'h02, 8'd0, 2);
    run_req("fc03_a0",      8'h03, 16'd0,      16'd1,   8'h00, 8'h02, 8'd0, 2);
    run_req("fc03_a4_q1",   8'h03, 16'd4,      16'd1,   8'h00, 8'h00, 8'd1, 4);
    run_req("fc03_a2_q4",   8'h03, 16'd2,      16'd4,   8'h00, 8'h02, 8'd0, 2);
    run_req("fc04_a3_q3",   8'h04, 16'd3,      16'd3,   8'h00, 8'h00, 8'd3, 6);
    run_req("fc04_a1_q8",   8'h04, 16'd1,      16'd8,   8'h00, 8'h00, 8'd8, 11);
    run_req("exc_in_02",    8'h03, 16'd1,      16'd1,   8'h02, 8'h02, 8'd0, 1);

    wr_mode = 0;
    run_req("fc06_ok",      8'h06, 16'd2,      16'h1234, 8'h00, 8'h00, 8'd1, -1);
    wr_mode = 1;
    run_req("fc06_fail",    8'h06, 16'd3,      16'hBEEF, 8'h00, 8'h04, 8'd0, -1);
    run_req("fc06_a5",      8'h06, 16'd5,      16'h0001, 8'h00, 8'h02, 8'd0, 2);
    run_req("fc06_a0",      8'h06, 16'd0,      16'h0001, 8'h00, 8'h02, 8'd0, 2);
    wr_mode = 2;
    run_req("fc06_timeout", 8'h06, 16'd4,      16'h5A5A, 8'h00, 8'h04, 8'd0, -2);
    wr_mode = 0;

    // A second request arriving mid-read must not disturb the one in progress.
    resp_q.push_back({8'h03, 8'h00, 8'd4});
    for (int k = 0; k < 4; k++) dp_q.push_back({8'(k), hold_m[k]});
    send_req(8'h03, 16'd1, 16'd4, 8'h00);
    rx_message_done = 1'b1;
    func_code = 8'h10;
    addr = 16'd9;
    data = 16'd9;
    exception_done = 1'b1;
    exception_in = 8'h02;
    @(negedge clk);
    rx_message_done = 1'b0;
    exception_done = 1'b0;
    exception_in = 8'h00;
    lat = 1;
    begin
      int l2;
      wait_done("busy_ignore", l2);
      lat = lat + l2;
    end
    chk("busy_ignore_latency", lat, 7);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (handler_done) extra++;
    end
    chk("busy_ignore_extra_done", extra, 0);
    chk("busy_ignore_dp_left", dp_q.size(), 0);
    chk("busy_ignore_fc_held", func_code_r, 8'h03);

    for (int k = 0; k < 8; k++) dp_q.push_back({8'(k), inp_m[k]});
    send_req(8'h04, 16'd1, 16'd8, 8'h00);
    repeat (3) @(negedge clk);
    chk("mid_read_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_read", all_out, 0);
    dp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (handler_done || dpram_wen) extra++;
    end
    chk("reset_no_done", extra, 0);
    chk("reset_resp_left", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
